// File: rtl/bitmap_pkg.sv
// Shared types and constants for the bitmap draw sequencer slice.
package bitmap_pkg;

   localparam int CORDW_DEF = 16;
   localparam int ADDRW_DEF = 24;
   localparam int ADDR_LAT  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WALK  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   // Number of coordinates currently travelling through the address pipeline.
   function automatic logic [1:0] popcount3(input logic [ADDR_LAT-1:0] v);
      popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/bitmap_addr.sv
// Three-stage pixel address pipeline: offset, row multiply plus bounds test, final sum.
module bitmap_addr #(
   parameter int CORDW = 16,
   parameter int ADDRW = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CORDW-1:0] bmpw,
   input  logic [CORDW-1:0] bmph,
   input  logic [CORDW-1:0] x,
   input  logic [CORDW-1:0] y,
   input  logic [CORDW-1:0] offx,
   input  logic [CORDW-1:0] offy,
   output logic [ADDRW-1:0] addr,
   output logic             clip
);

   logic [CORDW-1:0]   x1_r, y1_r, x2_r;
   logic [2*CORDW-1:0] row2_r;
   logic               clip2_r;
   logic [ADDRW-1:0]   addr_r;
   logic               clip_r;
   logic               clip1_s;

   // Negative or at/after the bitmap edge is outside the drawable area.
   assign clip1_s = x1_r[CORDW-1] || y1_r[CORDW-1] ||
                    ($signed(x1_r) >= $signed(bmpw)) || ($signed(y1_r) >= $signed(bmph));

   // Pipeline registers for all three stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x1_r    <= {CORDW{1'b0}};
         y1_r    <= {CORDW{1'b0}};
         x2_r    <= {CORDW{1'b0}};
         row2_r  <= {(2*CORDW){1'b0}};
         clip2_r <= 1'b0;
         addr_r  <= {ADDRW{1'b0}};
         clip_r  <= 1'b0;
      end else begin
         x1_r    <= x + offx;
         y1_r    <= y + offy;
         x2_r    <= x1_r;
         row2_r  <= $signed({{CORDW{y1_r[CORDW-1]}}, y1_r}) * $signed({{CORDW{bmpw[CORDW-1]}}, bmpw});
         clip2_r <= clip1_s;
         addr_r  <= row2_r[ADDRW-1:0] + {{(ADDRW-CORDW){x2_r[CORDW-1]}}, x2_r};
         clip_r  <= clip2_r;
      end
   end

   assign addr = addr_r;
   assign clip = clip_r;

endmodule

// File: rtl/bitmap_px_fifo.sv
// Synchronous pixel-address FIFO with occupancy count; DEPTH must be a power of two.
module bitmap_px_fifo #(
   parameter int DW    = 24,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s, pop_ok_s;

   assign empty     = (count_r == {(AW+1){1'b0}});
   assign push_ok_s = push && (count_r != (AW+1)'(DEPTH));
   assign pop_ok_s  = pop && !empty;

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/bitmap_draw_seq.sv
// Raster-order rectangle walker feeding bitmap_addr into a credit-managed output FIFO.
// Define BITMAP_DRAW_CLIPCNT_EN to add the saturating clip_count output.
module bitmap_draw_seq
   import bitmap_pkg::*;
#(
   parameter int CORDW      = CORDW_DEF,
   parameter int ADDRW      = ADDRW_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CORDW-1:0] rect_x,
   input  logic [CORDW-1:0] rect_y,
   input  logic [CORDW-1:0] rect_w,
   input  logic [CORDW-1:0] rect_h,
   input  logic [CORDW-1:0] bmpw,
   input  logic [CORDW-1:0] bmph,
   input  logic [CORDW-1:0] offx,
   input  logic [CORDW-1:0] offy,
   output logic             busy,
   output logic             done,
   output logic             px_valid,
   input  logic             px_ready,
   output logic [ADDRW-1:0] px_addr
`ifdef BITMAP_DRAW_CLIPCNT_EN
   ,
   output logic [CORDW-1:0] clip_count
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t              state_r, state_s;
   logic [CORDW-1:0]    x_r, y_r, rx_r, x_end_r, y_end_r;
   logic [CORDW-1:0]    bmpw_r, bmph_r, offx_r, offy_r;
   logic [ADDR_LAT-1:0] vld_r;
   logic [CW-1:0]       fifo_count_s;
   logic [CW:0]         used_s;
   logic [ADDRW-1:0]    ba_addr_s;
   logic                start_ok_s, empty_rect_s, issue_s, last_s;
   logic                push_s, pop_s, fifo_empty_s, clip_s, drained_s;

   assign start_ok_s   = (state_r == IDLE) && start;
   assign empty_rect_s = rect_w[CORDW-1] || (rect_w == {CORDW{1'b0}}) ||
                         rect_h[CORDW-1] || (rect_h == {CORDW{1'b0}});
   // Credits count both queued entries and results still inside the pipeline.
   assign used_s       = {1'b0, fifo_count_s} + (CW+1)'(popcount3(vld_r));
   assign issue_s      = (state_r == WALK) && (used_s < (CW+1)'(FIFO_DEPTH));
   assign last_s       = (x_r == x_end_r) && (y_r == y_end_r);
   assign push_s       = vld_r[ADDR_LAT-1] && !clip_s;
   assign pop_s        = !fifo_empty_s && px_ready;
   assign drained_s    = (vld_r == {ADDR_LAT{1'b0}}) &&
                         (fifo_empty_s || ((fifo_count_s == CW'(1)) && pop_s));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = empty_rect_s ? FIN : WALK;
            end else begin
               state_s = IDLE;
            end
         end
         WALK: begin
            if (issue_s && last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = WALK;
            end
         end
         DRAIN: begin
            if (drained_s) begin
               state_s = FIN;
            end else begin
               state_s = DRAIN;
            end
         end
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy = (state_r != IDLE);
      done = (state_r == FIN);
   end

   // Latched job parameters and raster-order coordinate counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r     <= {CORDW{1'b0}};
         y_r     <= {CORDW{1'b0}};
         rx_r    <= {CORDW{1'b0}};
         x_end_r <= {CORDW{1'b0}};
         y_end_r <= {CORDW{1'b0}};
         bmpw_r  <= {CORDW{1'b0}};
         bmph_r  <= {CORDW{1'b0}};
         offx_r  <= {CORDW{1'b0}};
         offy_r  <= {CORDW{1'b0}};
      end else if (start_ok_s) begin
         x_r     <= rect_x;
         y_r     <= rect_y;
         rx_r    <= rect_x;
         x_end_r <= rect_x + rect_w - CORDW'(1);
         y_end_r <= rect_y + rect_h - CORDW'(1);
         bmpw_r  <= bmpw;
         bmph_r  <= bmph;
         offx_r  <= offx;
         offy_r  <= offy;
      end else if (issue_s) begin
         if (x_r == x_end_r) begin
            x_r <= rx_r;
            y_r <= y_r + CORDW'(1);
         end else begin
            x_r <= x_r + CORDW'(1);
         end
      end
   end

   // In-flight marker, aligned with the address pipeline latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_r <= {ADDR_LAT{1'b0}};
      end else begin
         vld_r <= {vld_r[ADDR_LAT-2:0], issue_s};
      end
   end

   bitmap_addr #(.CORDW(CORDW), .ADDRW(ADDRW)) u_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .bmpw  (bmpw_r),
      .bmph  (bmph_r),
      .x     (x_r),
      .y     (y_r),
      .offx  (offx_r),
      .offy  (offy_r),
      .addr  (ba_addr_s),
      .clip  (clip_s)
   );

   bitmap_px_fifo #(.DW(ADDRW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .din   (ba_addr_s),
      .pop   (pop_s),
      .dout  (px_addr),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   assign px_valid = !fifo_empty_s;

`ifdef BITMAP_DRAW_CLIPCNT_EN
   logic [CORDW-1:0] clip_cnt_r;

   // Saturating count of clipped returns for the current job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_cnt_r <= {CORDW{1'b0}};
      end else if (start_ok_s) begin
         clip_cnt_r <= {CORDW{1'b0}};
      end else if (vld_r[ADDR_LAT-1] && clip_s && (clip_cnt_r != {CORDW{1'b1}})) begin
         clip_cnt_r <= clip_cnt_r + CORDW'(1);
      end
   end

   assign clip_count = clip_cnt_r;
`endif

endmodule
